axil_selftest_master: RTL and testbench
=======================================

// Module: axil_selftest_master
// PURPOSE
//  Synthesizable AXI4-Lite master. Sits directly upstream of the memtest S00_AXI register slave.
//  On start it writes N generated vectors to consecutive registers, reading each back after its write.
//  Compares every readback and reports pass, error count and first failing index.
//  Replaces the simulation BFM for on-hardware bring-up of the slave.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32            address width
//  C_M_AXI_DATA_WIDTH  32            data width (WSTRB all ones)
//  C_NUM_VECTORS       4             vectors per run, 1..16
//  C_BASE_ADDR         32'h0         first register address; vector i at C_BASE_ADDR+4*i
//  C_SEED              32'h0101FFFF  data_i = C_SEED + i*32'h11111111, mod 2^32
//  C_TIMEOUT           255           max wait cycles per handshake, 1..255
// PORTS
//  M_AXI_ACLK     in   1   clock
//  M_AXI_ARESETN  in   1   synchronous reset, active low
//  start          in   1   one-cycle run request; ignored while busy
//  busy           out  1   run in progress
//  done           out  1   run finished; held until next accepted start
//  pass           out  1   valid when done: 1 = no errors
//  err_count      out  8   readback mismatches + non-OKAY responses, saturating at 255
//  fail_index     out  4   index of first failing vector; 0 if none
//  timeout        out  1   a handshake exceeded C_TIMEOUT
//  M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in; M_AXI_WDATA/WSTRB/WVALID out, WREADY in
//  M_AXI_BRESP/BVALID in, BREADY out; M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in
//  M_AXI_RDATA/RRESP/RVALID in, RREADY out; AWPROT=ARPROT=3'b000
// BEHAVIOUR
//  Reset: all VALID/READY, busy, done, pass, err_count, fail_index and timeout are 0; state IDLE.
//  Reset mid-run drops all VALIDs the next cycle and returns to IDLE; no status is kept.
//  FSM: IDLE -> WR -> WRESP -> RD -> RDATA -> CHECK -> (i+1<N ? WR : DONE); DONE -> WR on start.
//  Start in IDLE/DONE clears status and i, sets busy, and enters WR; AWVALID and WVALID rise the next cycle.
//  WR asserts AWVALID and WVALID together; each drops on its own handshake.
//  WR exits when both handshakes have occurred, including same-cycle or reversed order.
//  WRESP: BREADY=1; on BVALID, if BRESP!=2'b00 then error++.
//  RD: ARVALID=1 with ARADDR=WR address until ARREADY. RDATA: RREADY=1; capture RDATA/RRESP on RVALID.
//  CHECK, one cycle: error++ per mismatch (RDATA!=data_i) and per non-OKAY RRESP (max +2 per vector).
//   First error sets fail_index=i; later errors do not change it.
//  VALID never drops before its handshake, and address/data are stable while VALID is high.
//  Timeout: a counter reloads on every state entry and counts cycles spent waiting in WR/WRESP/RD/RDATA.
//   On reaching C_TIMEOUT: timeout=1, err_count++, all VALID/READY=0, go to DONE.
//   This abort is only for a dead slave; the slave must be reset afterwards.
//  DONE: busy=0, done=1, pass=(err_count==0 && !timeout).
//  err_count saturates at 255 and never wraps; address increments by 4 with natural wrap.
// CONFIGURATION
//  SELFTEST_ERR_INJECT_EN defined: adds input err_inject (1b), sampled on accepted start.
//   If set, expected data for vector 0 has bit 0 inverted, forcing a mismatch (bench self-check).
//  Undefined: the port is absent and expected data is always data_i.
// STRUCTURE
//  Package axil_selftest_pkg: state enum, RESP_OKAY=2'b00, STRIDE=32'h11111111, ADDR_STEP=4.
//  Sub-module axil_selftest_timeout: 8-bit reloadable down-counter with expiry flag.
//  Everything else is in this module.
// TESTING
//  1 Zero-wait echo slave, start -> writes 0101FFFF,12131110,23242221,34353332 to 0x0..0xC; done, pass=1, err_count=0.
//  2 Slave AWREADY 3 cycles before WREADY, then WREADY before AWREADY; ARREADY/RVALID delayed 5 cycles -> pass=1.
//   Bench checks VALID stays asserted and addr/data stay stable until handshake.
//  3 Slave corrupts read of 0x8 (returns 0) and RRESP=SLVERR at 0xC -> err_count=2, fail_index=2, pass=0.
//  4 Slave never asserts BVALID -> timeout=1 after 255 wait cycles in WRESP; done=1, pass=0, BREADY=0 after abort.
//  5 Reset asserted during RD, then start -> all outputs 0 after reset; new run passes from vector 0.
//  6 With SELFTEST_ERR_INJECT_EN and err_inject=1 -> err_count=1, fail_index=0; start pulses while busy are ignored.

Source files
------------

// File: rtl/axil_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite self-test master.
package axil_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RD,
    ST_RDATA,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] STRIDE    = 32'h1111_1111;
  localparam int unsigned ADDR_STEP = 4;

  // Adds a small increment to the 8-bit error counter without wrapping past 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/axil_selftest_timeout.sv
// Reloadable 8-bit down-counter; o_expired marks the last permitted wait cycle.
module axil_selftest_timeout
  import axil_selftest_pkg::*;
#(
  parameter logic [7:0] C_LOAD = 8'd255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reload,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= C_LOAD;
    end else if (i_reload) begin
      r_cnt <= C_LOAD;
    end else if (i_enable && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // A count of 1 means the current wait cycle is the C_LOAD-th since entry.
  assign o_expired = (r_cnt == 8'd1);

endmodule

// File: rtl/axil_selftest_master.sv
// AXI4-Lite write/readback self-test master for bring-up of a register slave.
// Optional feature macro: SELFTEST_ERR_INJECT_EN (adds err_inject input).
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    C_NUM_VECTORS      = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  C_BASE_ADDR        = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]  C_SEED             = 32'h0101_FFFF,
  parameter int unsigned                    C_TIMEOUT          = 255
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              start,
`ifdef SELFTEST_ERR_INJECT_EN
  input  logic                              err_inject,
`endif
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        err_count,
  output logic [3:0]                        fail_index,
  output logic                              timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam logic [3:0]                    LP_LAST_IDX = 4'(C_NUM_VECTORS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LP_ADDR_INC = C_M_AXI_ADDR_WIDTH'(ADDR_STEP);
  localparam logic [C_M_AXI_DATA_WIDTH-1:0] LP_DATA_INC = C_M_AXI_DATA_WIDTH'(STRIDE);
  localparam logic [7:0]                    LP_TIMEOUT  = 8'(C_TIMEOUT);

  state_t                          r_state;
  state_t                          w_next;
  logic [3:0]                      r_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_data;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                      r_rresp;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic [7:0]                      r_err_count;
  logic [3:0]                      r_fail_index;
  logic                            r_fail_seen;
  logic                            r_timeout;

  logic                            w_start_acc;
  logic                            w_last;
  logic                            w_wait;
  logic                            w_expired;
  logic                            w_abort;
  logic [1:0]                      w_err_inc;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_expected;
  logic                            w_awvalid;
  logic                            w_wvalid;
  logic                            w_bready;
  logic                            w_arvalid;
  logic                            w_rready;

`ifdef SELFTEST_ERR_INJECT_EN
  logic r_inject;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_inject <= 1'b0;
    end else if (w_start_acc) begin
      r_inject <= err_inject;
    end
  end

  assign w_expected = (r_inject && (r_idx == 4'd0))
                      ? (r_data ^ {{(C_M_AXI_DATA_WIDTH-1){1'b0}}, 1'b1})
                      : r_data;
`else
  assign w_expected = r_data;
`endif

  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last      = (r_idx == LP_LAST_IDX);

  axil_selftest_timeout #(
    .C_LOAD (LP_TIMEOUT)
  ) u_timeout (
    .i_clk     (M_AXI_ACLK),
    .i_rst_n   (M_AXI_ARESETN),
    .i_reload  (w_next != r_state),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  assign w_abort = w_wait && w_expired;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_wait    = 1'b0;
    w_err_inc = 2'd0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = ST_WR;
      end
      ST_WR: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        // Either channel may complete first, or both in the same cycle.
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) w_next = ST_WRESP;
        else w_wait = 1'b1;
      end
      ST_WRESP: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) begin
          w_next = ST_RD;
          if (M_AXI_BRESP != RESP_OKAY) w_err_inc = 2'd1;
        end else begin
          w_wait = 1'b1;
        end
      end
      ST_RD: begin
        w_arvalid = 1'b1;
        if (M_AXI_ARREADY) w_next = ST_RDATA;
        else w_wait = 1'b1;
      end
      ST_RDATA: begin
        w_rready = 1'b1;
        if (M_AXI_RVALID) w_next = ST_CHECK;
        else w_wait = 1'b1;
      end
      ST_CHECK: begin
        w_err_inc = {1'b0, (r_rdata != w_expected)} + {1'b0, (r_rresp != RESP_OKAY)};
        w_next    = w_last ? ST_DONE : ST_WR;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next    = ST_DONE;
      w_err_inc = 2'd1;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_idx        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rdata      <= '0;
      r_rresp      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_err_count  <= '0;
      r_fail_index <= '0;
      r_fail_seen  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_idx        <= '0;
        r_addr       <= C_BASE_ADDR;
        r_data       <= C_SEED;
        r_aw_done    <= 1'b0;
        r_w_done     <= 1'b0;
        r_err_count  <= '0;
        r_fail_index <= '0;
        r_fail_seen  <= 1'b0;
        r_timeout    <= 1'b0;
      end else begin
        if (r_state == ST_WR) begin
          if (w_next != ST_WR) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (M_AXI_AWREADY) r_aw_done <= 1'b1;
            if (M_AXI_WREADY)  r_w_done  <= 1'b1;
          end
        end
        if ((r_state == ST_RDATA) && M_AXI_RVALID) begin
          r_rdata <= M_AXI_RDATA;
          r_rresp <= M_AXI_RRESP;
        end
        if ((r_state == ST_CHECK) && !w_last) begin
          r_idx  <= r_idx + 4'd1;
          r_addr <= r_addr + LP_ADDR_INC;
          r_data <= r_data + LP_DATA_INC;
        end
        if (w_err_inc != 2'd0) begin
          r_err_count <= sat_add8(r_err_count, w_err_inc);
          if (!r_fail_seen) begin
            r_fail_seen  <= 1'b1;
            r_fail_index <= r_idx;
          end
        end
        if (w_abort) r_timeout <= 1'b1;
      end
    end
  end

  assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done          = (r_state == ST_DONE);
  assign pass          = done && (r_err_count == 8'd0) && !r_timeout;
  assign err_count     = r_err_count;
  assign fail_index    = r_fail_index;
  assign timeout       = r_timeout;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_WDATA   = r_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = w_arvalid;
  assign M_AXI_RREADY  = w_rready;

endmodule

// File: tb/tb_axil_selftest_master.sv
// Directed bench for axil_selftest_master with a configurable AXI4-Lite register slave.
module tb_axil_selftest_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        err_inject;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count;
  logic [3:0]  fail_index;
  logic [31:0] m_awaddr, m_wdata, m_araddr, s_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_rresp;

  int checks   = 0;
  int failures = 0;

  // Slave behaviour knobs, written only by the stimulus block.
  logic        reorder    = 1'b0;
  int unsigned rd_dly     = 0;
  logic        no_bvalid  = 1'b0;
  logic        corrupt8   = 1'b0;
  logic        slverr_c   = 1'b0;
  logic        mon_en     = 1'b0;

  axil_selftest_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .start         (start),
`ifdef SELFTEST_ERR_INJECT_EN
    .err_inject    (err_inject),
`endif
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .fail_index    (fail_index),
    .timeout       (timeout),
    .M_AXI_AWADDR  (m_awaddr),
    .M_AXI_AWPROT  (m_awprot),
    .M_AXI_AWVALID (m_awvalid),
    .M_AXI_AWREADY (s_awready),
    .M_AXI_WDATA   (m_wdata),
    .M_AXI_WSTRB   (m_wstrb),
    .M_AXI_WVALID  (m_wvalid),
    .M_AXI_WREADY  (s_wready),
    .M_AXI_BRESP   (2'b00),
    .M_AXI_BVALID  (s_bvalid),
    .M_AXI_BREADY  (m_bready),
    .M_AXI_ARADDR  (m_araddr),
    .M_AXI_ARPROT  (m_arprot),
    .M_AXI_ARVALID (m_arvalid),
    .M_AXI_ARREADY (s_arready),
    .M_AXI_RDATA   (s_rdata),
    .M_AXI_RRESP   (s_rresp),
    .M_AXI_RVALID  (s_rvalid),
    .M_AXI_RREADY  (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [31:0] mem [16];
  int unsigned aw_cnt, w_cnt, ar_cnt, r_cnt, aw_need, w_need;
  int unsigned aw_hs_count;
  logic        aw_got, w_got, r_pending;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic        aw_hs, w_hs, ag_n, wg_n;
  logic [31:0] a_n, d_n;

  assign aw_need   = (reorder && m_awaddr[2])  ? 3 : 0;
  assign w_need    = (reorder && !m_awaddr[2]) ? 3 : 0;
  assign s_awready = m_awvalid && (aw_cnt >= aw_need);
  assign s_wready  = m_wvalid  && (w_cnt  >= w_need);
  assign s_arready = m_arvalid && (ar_cnt >= rd_dly);
  assign aw_hs     = m_awvalid && s_awready;
  assign w_hs      = m_wvalid  && s_wready;
  assign ag_n      = aw_got || aw_hs;
  assign wg_n      = w_got  || w_hs;
  assign a_n       = aw_hs ? m_awaddr : aw_addr_q;
  assign d_n       = w_hs  ? m_wdata  : w_data_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pending <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= 2'b00;
      aw_addr_q <= '0; w_data_q <= '0; ar_addr_q <= '0;
    end else begin
      aw_cnt <= (m_awvalid && !s_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid  && !s_wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_arvalid && !s_arready) ? ar_cnt + 1 : 0;
      if (aw_hs) aw_hs_count <= aw_hs_count + 1;
      aw_addr_q <= a_n;
      w_data_q  <= d_n;
      if (ag_n && wg_n) begin
        mem[a_n[5:2]] <= d_n;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!no_bvalid) s_bvalid <= 1'b1;
      end else begin
        aw_got <= ag_n;
        w_got  <= wg_n;
      end
      if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      if (m_arvalid && s_arready) begin
        r_pending <= 1'b1;
        ar_addr_q <= m_araddr;
        r_cnt     <= 0;
      end else if (r_pending && !s_rvalid) begin
        if (r_cnt >= rd_dly) begin
          s_rvalid  <= 1'b1;
          s_rdata   <= (corrupt8 && ar_addr_q == 32'h8) ? 32'h0 : mem[ar_addr_q[5:2]];
          s_rresp   <= (slverr_c && ar_addr_q == 32'hC) ? 2'b10 : 2'b00;
          r_pending <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
      if (s_rvalid && m_rready) s_rvalid <= 1'b0;
    end
  end

  initial aw_hs_count = 0;

  // ---------------- VALID/payload stability monitor ----------------
  int          viol = 0;
  logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0;
  logic [31:0] pa_aw, pd_w, pa_ar;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if ((pv_aw && !(m_awvalid && m_awaddr == pa_aw)) ||
          (pv_w  && !(m_wvalid  && m_wdata  == pd_w))  ||
          (pv_ar && !(m_arvalid && m_araddr == pa_ar)))
        viol <= viol + 1;
    end
    pv_aw <= m_awvalid && !s_awready; pa_aw <= m_awaddr;
    pv_w  <= m_wvalid  && !s_wready;  pd_w  <= m_wdata;
    pv_ar <= m_arvalid && !s_arready; pa_ar <= m_araddr;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    busy, 1'b0);
    chk({tag, "_done"},    done, 1'b0);
    chk({tag, "_pass"},    pass, 1'b0);
    chk({tag, "_err"},     err_count, 8'd0);
    chk({tag, "_fidx"},    fail_index, 4'd0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_valids"},  {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, bcyc;
  int unsigned aw_base;

  initial begin
    rst_n = 1'b0; start = 1'b0; err_inject = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait echo slave
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_awvalid", {m_awvalid, m_wvalid}, 2'b11);
    chk("t1_awaddr0", m_awaddr, 32'h0);
    chk("t1_wdata0", m_wdata, 32'h0101FFFF);
    chk("t1_prot_strb", {m_awprot, m_arprot, m_wstrb}, {3'b000, 3'b000, 4'hF});
    wait_done("t1_done");
    chk("t1_pass", pass, 1'b1);
    chk("t1_err", err_count, 8'd0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_mem0", mem[0], 32'h0101FFFF);
    chk("t1_mem1", mem[1], 32'h12131110);
    chk("t1_mem2", mem[2], 32'h23242221);
    chk("t1_mem3", mem[3], 32'h34353332);

    // 2: reordered write handshakes, slow reads, extra start pulses while busy
    reorder = 1'b1; rd_dly = 5; mon_en = 1'b1;
    aw_base = aw_hs_count;
    pulse_start();
    chk("t2_done_cleared", done, 1'b0);
    repeat (10) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done("t2_done");
    chk("t2_pass", pass, 1'b1);
    chk("t2_err", err_count, 8'd0);
    chk("t2_aw_count", aw_hs_count - aw_base, 32'd4);
    chk("t2_stable_valids", viol, 32'd0);
    mon_en = 1'b0; reorder = 1'b0; rd_dly = 0;

    // 3: corrupt read at 0x8, SLVERR at 0xC
    corrupt8 = 1'b1; slverr_c = 1'b1;
    pulse_start();
    wait_done("t3_done");
    chk("t3_err", err_count, 8'd2);
    chk("t3_fidx", fail_index, 4'd2);
    chk("t3_pass", pass, 1'b0);
    chk("t3_timeout", timeout, 1'b0);
    corrupt8 = 1'b0; slverr_c = 1'b0;

    // 4: slave never returns BVALID
    no_bvalid = 1'b1;
    pulse_start();
    n = 0;
    while (!m_bready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_bready_rise", m_bready, 1'b1);
    bcyc = 0; n = 0;
    while (m_bready && n < 400) begin
      bcyc++;
      @(negedge clk);
      n++;
    end
    chk("t4_wait_cycles", bcyc, 32'd255);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_done", done, 1'b1);
    chk("t4_pass", pass, 1'b0);
    chk("t4_err", err_count, 8'd1);
    chk("t4_fidx", fail_index, 4'd0);
    chk("t4_ready_valid_low", {m_bready, m_awvalid, m_wvalid, m_arvalid, m_rready}, 5'b0);
    no_bvalid = 1'b0;

    // 5: reset while the read address is pending, then a fresh run
    rd_dly = 5;
    pulse_start();
    n = 0;
    while (!m_arvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_rd", m_arvalid, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5_in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t5_after_reset");
    rd_dly = 0;
    aw_base = aw_hs_count;
    pulse_start();
    chk("t5_restart_addr", m_awaddr, 32'h0);
    chk("t5_restart_data", m_wdata, 32'h0101FFFF);
    wait_done("t5_done");
    chk("t5_pass", pass, 1'b1);
    chk("t5_err", err_count, 8'd0);
    chk("t5_aw_count", aw_hs_count - aw_base, 32'd4);

`ifdef SELFTEST_ERR_INJECT_EN
    // 6: injected expectation error on vector 0
    err_inject = 1'b1;
    pulse_start();
    err_inject = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done("t6_done");
    chk("t6_err", err_count, 8'd1);
    chk("t6_fidx", fail_index, 4'd0);
    chk("t6_pass", pass, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
